// File: rtl/hpm_counter_bank_if.sv
// Bus between the privileged unit and the counter bank: W-stage event strobes,
// CSR-side counter/inhibit/event-select access, and the overflow status outputs.
interface hpm_counter_bank_if #(
   parameter int XLEN         = 64,
   parameter int NUM_COUNTERS = 32,
   parameter int NUM_EVENTS   = 16
);
   localparam int EVW = $clog2(NUM_EVENTS + 1);

   logic                    InstrRetiredW;
   logic [NUM_EVENTS-1:0]   EventsW;
   logic                    CntWriteEn;
   logic [4:0]              CntIdx;
   logic                    CntHi;
   logic [XLEN-1:0]         CntWriteData;
   logic                    InhibitWriteEn;
   logic [NUM_COUNTERS-1:0] InhibitWriteData;
   logic                    EvSelWriteEn;
   logic [EVW-1:0]          EvSelWriteData;
   logic [NUM_COUNTERS-1:0] OvfClear;
   logic [XLEN-1:0]         CntReadData;
   logic [NUM_COUNTERS-1:0] OvfFlags;
   logic                    OvfIrq;

   modport master (
      output InstrRetiredW, EventsW, CntWriteEn, CntIdx, CntHi, CntWriteData,
             InhibitWriteEn, InhibitWriteData, EvSelWriteEn, EvSelWriteData, OvfClear,
      input  CntReadData, OvfFlags, OvfIrq
   );

   modport slave (
      input  InstrRetiredW, EventsW, CntWriteEn, CntIdx, CntHi, CntWriteData,
             InhibitWriteEn, InhibitWriteData, EvSelWriteEn, EvSelWriteData, OvfClear,
      output CntReadData, OvfFlags, OvfIrq
   );
endinterface

// File: rtl/hpm_counter_bank.sv
// Machine-mode counter bank: mcycle, time (reads zero), minstret and programmable
// mhpmcounters with event select, inhibit and sticky overflow flag plus a registered IRQ.
module hpm_counter_bank #(
   parameter int XLEN         = 64,
   parameter int NUM_COUNTERS = 32,
   parameter int NUM_EVENTS   = 16
) (
   input logic               clk,
   input logic               reset,
   hpm_counter_bank_if.slave bus
);
   localparam int EVW = $clog2(NUM_EVENTS + 1);
   localparam logic [NUM_COUNTERS-1:0] PROG_MASK = ~NUM_COUNTERS'(7);

   logic [63:0]             cnt_q   [NUM_COUNTERS];
   logic [63:0]             cnt_d   [NUM_COUNTERS];
   logic [EVW-1:0]          evsel_q [NUM_COUNTERS];
   logic [EVW-1:0]          evsel_d [NUM_COUNTERS];
   logic [NUM_COUNTERS-1:0] inhibit_q, inhibit_d;
   logic [NUM_COUNTERS-1:0] ovf_q, ovf_d;
   logic                    irq_q;
   logic [NUM_COUNTERS-1:0] inc, wr_hit, ovf_set;
   logic [NUM_EVENTS:0]     ev_ext;
   logic [63:0]             rd_sel;

   function automatic logic [63:0] merge_write(input logic [63:0] old,
                                               input logic [XLEN-1:0] data,
                                               input logic hi);
      logic [63:0] r;
      if (XLEN >= 64) r = 64'(data);
      else if (hi)    r = {data[31:0], old[31:0]};
      else            r = {old[63:32], data[31:0]};
      return r;
   endfunction

   function automatic logic [XLEN-1:0] read_slice(input logic [63:0] v, input logic hi);
      logic [XLEN-1:0] r;
      if (XLEN >= 64) r = XLEN'(v);
      else if (hi)    r = XLEN'(v[63:32]);
      else            r = XLEN'(v[31:0]);
      return r;
   endfunction

   // Event k lives at ev_ext[k]; select 0 lands on the constant-zero bit.
   always_comb begin
      ev_ext    = {bus.EventsW, 1'b0};
      inc       = '0;
      wr_hit    = '0;
      ovf_set   = '0;
      inhibit_d = inhibit_q;
      for (int n = 0; n < NUM_COUNTERS; n++) begin
         cnt_d[n]   = cnt_q[n];
         evsel_d[n] = evsel_q[n];
         wr_hit[n]  = bus.CntWriteEn && (bus.CntIdx == 5'(n)) && (n != 1);
         if (n == 0)      inc[n] = 1'b1;
         else if (n == 2) inc[n] = bus.InstrRetiredW;
         else if (n >= 3) inc[n] = ev_ext[evsel_q[n]];
         inc[n]     = inc[n] && !inhibit_q[n];
         ovf_set[n] = inc[n] && !wr_hit[n] && (n >= 3) && (&cnt_q[n]);
         if (n == 1)         cnt_d[n] = '0;
         else if (wr_hit[n]) cnt_d[n] = merge_write(cnt_q[n], bus.CntWriteData, bus.CntHi);
         else if (inc[n])    cnt_d[n] = cnt_q[n] + 64'd1;
         if (bus.EvSelWriteEn && (bus.CntIdx == 5'(n)) && (n >= 3))
            evsel_d[n] = (bus.EvSelWriteData > EVW'(NUM_EVENTS)) ? '0 : bus.EvSelWriteData;
      end
      // A wrap in the same cycle as a clear leaves the flag set.
      ovf_d = ((ovf_q & ~(bus.OvfClear | wr_hit)) | ovf_set) & PROG_MASK;
      if (bus.InhibitWriteEn) inhibit_d = bus.InhibitWriteData & ~NUM_COUNTERS'(2);
   end

   always_comb begin
      rd_sel = '0;
      for (int n = 0; n < NUM_COUNTERS; n++)
         if ((n != 1) && (bus.CntIdx == 5'(n))) rd_sel = cnt_q[n];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int n = 0; n < NUM_COUNTERS; n++) begin
            cnt_q[n]   <= '0;
            evsel_q[n] <= '0;
         end
         inhibit_q <= '0;
         ovf_q     <= '0;
         irq_q     <= 1'b0;
      end else begin
         for (int n = 0; n < NUM_COUNTERS; n++) begin
            cnt_q[n]   <= cnt_d[n];
            evsel_q[n] <= evsel_d[n];
         end
         inhibit_q <= inhibit_d;
         ovf_q     <= ovf_d;
         irq_q     <= |ovf_q;
      end
   end

   assign bus.CntReadData = read_slice(rd_sel, bus.CntHi);
   assign bus.OvfFlags    = ovf_q;
   assign bus.OvfIrq      = irq_q;
endmodule

// File: tb/tb_hpm_counter_bank.sv
// Bench for hpm_counter_bank: directed scenarios plus randomized traffic checked
// against an array-based reference model of the counter bank.
module tb_hpm_counter_bank;
   localparam int NC = 32;
   localparam int NE = 16;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   hpm_counter_bank_if #(.XLEN(64), .NUM_COUNTERS(NC), .NUM_EVENTS(NE)) b ();
   hpm_counter_bank_if #(.XLEN(32), .NUM_COUNTERS(5), .NUM_EVENTS(2)) s ();

   hpm_counter_bank #(.XLEN(64), .NUM_COUNTERS(NC), .NUM_EVENTS(NE)) dut (
      .clk(clk), .reset(reset), .bus(b));
   hpm_counter_bank #(.XLEN(32), .NUM_COUNTERS(5), .NUM_EVENTS(2)) dut32 (
      .clk(clk), .reset(reset), .bus(s));

   logic [63:0] m_cnt [NC];
   logic [4:0]  m_sel [NC];
   logic [31:0] m_inh, m_ovf;
   logic        m_irq;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] m_read(input int idx);
      return (idx == 1 || idx >= NC) ? 64'd0 : m_cnt[idx];
   endfunction

   task automatic model_reset();
      for (int n = 0; n < NC; n++) begin
         m_cnt[n] = '0;
         m_sel[n] = '0;
      end
      m_inh = '0;
      m_ovf = '0;
      m_irq = 1'b0;
   endtask

   task automatic model_step();
      m_irq = |m_ovf;
      for (int n = 0; n < NC; n++) begin
         logic inc, wr;
         int   e;
         e   = m_sel[n];
         wr  = b.CntWriteEn && (b.CntIdx == n) && (n != 1);
         inc = 1'b0;
         if (n == 0)      inc = 1'b1;
         else if (n == 2) inc = b.InstrRetiredW;
         else if (n >= 3) inc = (e != 0) && b.EventsW[e-1];
         if (m_inh[n]) inc = 1'b0;
         if (b.OvfClear[n] || wr) m_ovf[n] = 1'b0;
         if (wr) m_cnt[n] = b.CntWriteData;
         else if (inc) begin
            if (n >= 3 && m_cnt[n] == 64'hFFFF_FFFF_FFFF_FFFF) m_ovf[n] = 1'b1;
            m_cnt[n] = m_cnt[n] + 64'd1;
         end
         if (b.EvSelWriteEn && (b.CntIdx == n) && n >= 3)
            m_sel[n] = (b.EvSelWriteData > NE) ? 5'd0 : b.EvSelWriteData;
      end
      if (b.InhibitWriteEn) m_inh = b.InhibitWriteData & ~32'h2;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle();
      b.InstrRetiredW = 0; b.EventsW = '0; b.CntWriteEn = 0; b.CntIdx = '0; b.CntHi = 0;
      b.CntWriteData = '0; b.InhibitWriteEn = 0; b.InhibitWriteData = '0;
      b.EvSelWriteEn = 0; b.EvSelWriteData = '0; b.OvfClear = '0;
      s.InstrRetiredW = 0; s.EventsW = '0; s.CntWriteEn = 0; s.CntIdx = '0; s.CntHi = 0;
      s.CntWriteData = '0; s.InhibitWriteEn = 0; s.InhibitWriteData = '0;
      s.EvSelWriteEn = 0; s.EvSelWriteData = '0; s.OvfClear = '0;
   endtask

   task automatic rd(input int idx, output logic [63:0] v);
      b.CntIdx = 5'(idx);
      #1;
      v = b.CntReadData;
   endtask

   initial begin
      logic [63:0] v;
      int r;
      idle();
      model_reset();
      reset = 1'b1;
      #12;
      check_eq("reset_ovf", 64'(b.OvfFlags), 64'd0);
      check_eq("reset_irq", 64'(b.OvfIrq), 64'd0);
      rd(0, v); check_eq("reset_c0", v, 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // 10 cycles, 4 retirements
      for (int i = 0; i < 10; i++) begin
         b.InstrRetiredW = (i < 4);
         tick();
      end
      b.InstrRetiredW = 0;
      rd(0, v); check_eq("mcycle_10", v, 64'd10);
      rd(2, v); check_eq("minstret_4", v, 64'd4);
      rd(1, v); check_eq("time_zero", v, 64'd0);
      check_eq("irq_idle", 64'(b.OvfIrq), 64'd0);

      // Event 2 on counter 3, inhibited for the last two of five strobes
      b.EvSelWriteEn = 1; b.CntIdx = 3; b.EvSelWriteData = 5'd2;
      tick();
      b.EvSelWriteEn = 0;
      for (int i = 0; i < 5; i++) begin
         b.EventsW = 16'b10;
         b.InhibitWriteEn = (i == 2);
         b.InhibitWriteData = 32'h8;
         tick();
      end
      b.EventsW = '0; b.InhibitWriteEn = 1; b.InhibitWriteData = '0;
      tick();
      b.InhibitWriteEn = 0;
      rd(3, v); check_eq("evcnt_inhibit", v, 64'd3);

      // Wrap of counter 3 sets the flag, IRQ follows a cycle later
      b.CntWriteEn = 1; b.CntIdx = 3; b.CntWriteData = 64'hFFFF_FFFF_FFFF_FFFE;
      tick();
      b.CntWriteEn = 0; b.EventsW = 16'b10;
      tick(); tick();
      b.EventsW = '0;
      rd(3, v); check_eq("wrap_c3", v, 64'd0);
      check_eq("wrap_flags", 64'(b.OvfFlags), 64'h8);
      check_eq("wrap_irq_lag", 64'(b.OvfIrq), 64'd0);
      tick();
      check_eq("wrap_irq", 64'(b.OvfIrq), 64'd1);
      b.OvfClear = 32'h8;
      tick();
      b.OvfClear = '0;
      tick();
      check_eq("clr_flags", 64'(b.OvfFlags), 64'd0);
      check_eq("clr_irq", 64'(b.OvfIrq), 64'd0);

      // Write beats the free-running increment
      b.CntWriteEn = 1; b.CntIdx = 0; b.CntWriteData = 64'd100;
      tick();
      b.CntWriteEn = 0;
      rd(0, v); check_eq("wr_c0", v, 64'd100);
      tick();
      rd(0, v); check_eq("wr_c0_next", v, 64'd101);

      // 32-bit variant: half-word writes and out-of-range reads
      s.CntWriteEn = 1; s.CntIdx = 4; s.CntHi = 0; s.CntWriteData = 64'd9;
      tick();
      s.CntHi = 1; s.CntWriteData = 64'h1234_5678;
      tick();
      s.CntWriteEn = 0; s.CntHi = 0;
      #1 check_eq("x32_lo", 64'(s.CntReadData), 64'h9);
      s.CntHi = 1;
      #1 check_eq("x32_hi", 64'(s.CntReadData), 64'h1234_5678);
      s.CntIdx = 7;
      #1 check_eq("x32_oob", 64'(s.CntReadData), 64'd0);
      s.CntIdx = 1;
      #1 check_eq("x32_time", 64'(s.CntReadData), 64'd0);
      s.CntHi = 0;
      tick();

      // Randomized traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 15));
         b.InstrRetiredW    = 1'($urandom);
         b.EventsW          = 16'($urandom);
         b.CntIdx           = 5'($urandom);
         b.CntHi            = 1'($urandom);
         b.CntWriteEn       = (r == 0);
         b.CntWriteData     = $urandom_range(0, 1) ? {$urandom, $urandom}
                                                   : 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
         b.EvSelWriteEn     = (r <= 2);
         b.EvSelWriteData   = 5'($urandom);
         b.InhibitWriteEn   = (r == 3);
         b.InhibitWriteData = $urandom & $urandom & $urandom;
         b.OvfClear         = ($urandom_range(0, 7) == 0) ? $urandom : 32'd0;
         #1;
         check_eq("rnd_read", b.CntReadData, m_read(int'(b.CntIdx)));
         check_eq("rnd_flags", 64'(b.OvfFlags), 64'(m_ovf));
         check_eq("rnd_irq", 64'(b.OvfIrq), 64'(m_irq));
         tick();
      end
      idle();

      // Async reset with a flag pending
      b.CntWriteEn = 1; b.CntIdx = 3; b.CntWriteData = 64'hFFFF_FFFF_FFFF_FFFF;
      b.EvSelWriteEn = 1; b.EvSelWriteData = 5'd2;
      b.InhibitWriteEn = 1; b.InhibitWriteData = '0; b.OvfClear = '1;
      tick();
      idle();
      b.EventsW = 16'b10;
      tick();
      b.EventsW = '0;
      check_eq("pre_rst_bit3", 64'(b.OvfFlags[3]), 64'd1);
      check_eq("pre_rst_flags", 64'(b.OvfFlags), 64'(m_ovf));
      #3;
      reset = 1'b1;
      #1;
      model_reset();
      check_eq("arst_flags", 64'(b.OvfFlags), 64'd0);
      check_eq("arst_irq", 64'(b.OvfIrq), 64'd0);
      rd(0, v); check_eq("arst_c0", v, 64'd0);
      rd(3, v); check_eq("arst_c3", v, 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      tick(); tick(); tick();
      rd(0, v); check_eq("post_rst_c0", v, 64'd3);
      check_eq("post_rst_model", v, m_read(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
